// File: rtl/bf16_add_sub.sv
// Registered bfloat16 adder/subtractor, one result per cycle, one cycle of latency.
// Define BF16_SUBNORMAL_EN for gradual underflow; the default build flushes subnormals to zero.
module bf16_add_sub (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  input  logic        inst_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] c_o,
  output logic        out_valid_o,
  output logic        invalid_o,
  output logic        overflow_o,
  output logic        inexact_o
);

  logic       sa, sb;
  logic [7:0] ea, eb;
  logic [6:0] fa, fb;
  logic       nan_a, nan_b, inf_a, inf_b;
  logic [7:0] xa, xb, ma, mb;

  assign sa = a_i[15];
  assign sb = b_i[15] ^ ~inst_i;
  assign ea = a_i[14:7];
  assign eb = b_i[14:7];
  assign fa = a_i[6:0];
  assign fb = b_i[6:0];

  assign nan_a = (&ea) & (|fa);
  assign nan_b = (&eb) & (|fb);
  assign inf_a = (&ea) & ~(|fa);
  assign inf_b = (&eb) & ~(|fb);

`ifdef BF16_SUBNORMAL_EN
  assign xa = (ea == 8'd0) ? 8'd1 : ea;
  assign xb = (eb == 8'd0) ? 8'd1 : eb;
  assign ma = {|ea, fa};
  assign mb = {|eb, fb};
`else
  assign xa = ea;
  assign xb = eb;
  assign ma = (ea == 8'd0) ? 8'd0 : {1'b1, fa};
  assign mb = (eb == 8'd0) ? 8'd0 : {1'b1, fb};
`endif

  logic       a_ge_b, sl, eff_sub;
  logic [7:0] xl, xs, ml, ms, d;

  assign a_ge_b  = {xa, ma} >= {xb, mb};
  assign sl      = a_ge_b ? sa : sb;
  assign xl      = a_ge_b ? xa : xb;
  assign xs      = a_ge_b ? xb : xa;
  assign ml      = a_ge_b ? ma : mb;
  assign ms      = a_ge_b ? mb : ma;
  assign d       = xl - xs;
  assign eff_sub = sa ^ sb;

  // Aligned smaller operand: 8 mantissa bits, guard, round, sticky.
  logic [17:0] wide;
  logic [10:0] aligned;
  logic [11:0] sum;

  assign wide    = {ms, 10'd0} >> d;
  assign aligned = (d >= 8'd10) ? {10'd0, |ms} : {wide[17:8], |wide[7:0]};
  assign sum     = eff_sub ? {1'b0, ml, 3'b000} - {1'b0, aligned}
                           : {1'b0, ml, 3'b000} + {1'b0, aligned};

  logic [3:0]        lz, shamt;
  logic [10:0]       norm;
  logic [7:0]        man;
  logic              g, r, st, rnd_up;
  logic [8:0]        man_r;
  logic [7:0]        man_f, exp_enc;
  logic signed [9:0] exp_n, exp_r;

  always_comb begin
    lz = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (sum[i]) lz = 4'(10 - i);
    end
    shamt = lz;
`ifdef BF16_SUBNORMAL_EN
    // Never normalise below the minimum exponent; leftover leading zeros encode a subnormal.
    if ({4'd0, lz} >= xl) shamt = 4'(xl - 8'd1);
`endif
    norm = 11'd0;
    if (sum[11]) begin
      man   = sum[11:4];
      g     = sum[3];
      r     = sum[2];
      st    = |sum[1:0];
      exp_n = $signed({2'b00, xl}) + 10'sd1;
    end else begin
      norm  = sum[10:0] << shamt;
      man   = norm[10:3];
      g     = norm[2];
      r     = norm[1];
      st    = norm[0];
      exp_n = $signed({2'b00, xl}) - $signed({6'd0, shamt});
    end
    rnd_up  = g & (r | st | man[0]);
    man_r   = {1'b0, man} + {8'd0, rnd_up};
    man_f   = man_r[8] ? man_r[8:1] : man_r[7:0];
    exp_r   = man_r[8] ? exp_n + 10'sd1 : exp_n;
    exp_enc = man_f[7] ? exp_r[7:0] : 8'd0;
  end

  logic uflow;
`ifdef BF16_SUBNORMAL_EN
  assign uflow = 1'b0;
`else
  assign uflow = exp_n < 10'sd1;
`endif

  logic [15:0] res_d;
  logic        invalid_d, overflow_d, inexact_d;

  always_comb begin
    res_d      = 16'h0000;
    invalid_d  = 1'b0;
    overflow_d = 1'b0;
    inexact_d  = 1'b0;
    if (nan_a || nan_b) begin
      res_d = 16'h7FC0;
    end else if (inf_a && inf_b && (sa != sb)) begin
      res_d     = 16'h7FC0;
      invalid_d = 1'b1;
    end else if (inf_a) begin
      res_d = {sa, 8'hFF, 7'd0};
    end else if (inf_b) begin
      res_d = {sb, 8'hFF, 7'd0};
    end else if (sum == 12'd0) begin
      res_d = {sa & sb, 15'd0};
    end else if (uflow) begin
      res_d     = {sl, 15'd0};
      inexact_d = 1'b1;
    end else if (exp_r >= 10'sd255) begin
      res_d      = {sl, 8'hFF, 7'd0};
      overflow_d = 1'b1;
      inexact_d  = 1'b1;
    end else begin
      res_d     = {sl, exp_enc, man_f[6:0]};
      inexact_d = g | r | st;
    end
  end

  logic [15:0] c_q;
  logic        valid_q, invalid_q, overflow_q, inexact_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      c_q        <= 16'h0000;
      valid_q    <= 1'b0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      valid_q <= in_valid_i;
      if (in_valid_i) begin
        c_q        <= res_d;
        invalid_q  <= invalid_d;
        overflow_q <= overflow_d;
        inexact_q  <= inexact_d;
      end
    end
  end

  assign c_o         = c_q;
  assign out_valid_o = valid_q;
  assign invalid_o   = invalid_q;
  assign overflow_o  = overflow_q;
  assign inexact_o   = inexact_q;

endmodule

// File: tb/tb_bf16_add_sub.sv
// Self-checking bench for bf16_add_sub: directed cases plus random operands against an
// exact-integer reference model. Honours BF16_SUBNORMAL_EN like the design.
module tb_bf16_add_sub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        inst = 1'b1;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic [15:0] c;
  logic        out_valid, invalid, overflow, inexact;

  int checks = 0;
  int failures = 0;

  bf16_add_sub dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .inst_i     (inst),
    .a_i        (a),
    .b_i        (b),
    .c_o        (c),
    .out_valid_o(out_valid),
    .invalid_o  (invalid),
    .overflow_o (overflow),
    .inexact_o  (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] c;
    logic [2:0]  f;  // {invalid, overflow, inexact}
  } vec_t;

  vec_t dir[$];

  // Exact result: both operands as integers in units of 2^-133, then RNE to 8 significant bits.
  function automatic logic [18:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic add);
    logic         sx, sy, neg, infx, infy, nanx, nany;
    int           ex, ey, p, sh, e;
    logic [7:0]   mx, my;
    logic [299:0] vx, vy, s, q, rem, half;
    sx   = x[15];
    sy   = y[15] ^ !add;
    nanx = (x[14:7] == 8'hFF) && (x[6:0] != 0);
    nany = (y[14:7] == 8'hFF) && (y[6:0] != 0);
    infx = (x[14:7] == 8'hFF) && (x[6:0] == 0);
    infy = (y[14:7] == 8'hFF) && (y[6:0] == 0);
    if (nanx || nany) return {3'b000, 16'h7FC0};
    if (infx && infy && (sx != sy)) return {3'b100, 16'h7FC0};
    if (infx) return {3'b000, sx, 8'hFF, 7'd0};
    if (infy) return {3'b000, sy, 8'hFF, 7'd0};
    ex = int'(x[14:7]);
    ey = int'(y[14:7]);
`ifdef BF16_SUBNORMAL_EN
    mx = (ex == 0) ? {1'b0, x[6:0]} : {1'b1, x[6:0]};
    my = (ey == 0) ? {1'b0, y[6:0]} : {1'b1, y[6:0]};
`else
    mx = (ex == 0) ? 8'd0 : {1'b1, x[6:0]};
    my = (ey == 0) ? 8'd0 : {1'b1, y[6:0]};
`endif
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    vx = 300'(mx) << (ex - 1);
    vy = 300'(my) << (ey - 1);
    if (sx == sy) begin
      s = vx + vy;  neg = sx;
    end else if (vx >= vy) begin
      s = vx - vy;  neg = sx;
    end else begin
      s = vy - vx;  neg = sy;
    end
    if (s == 0) return {3'b000, sx & sy, 15'd0};
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    if (p < 7) begin
`ifdef BF16_SUBNORMAL_EN
      return {3'b000, neg, 8'h00, s[6:0]};
`else
      return {3'b001, neg, 15'd0};
`endif
    end
    sh  = p - 7;
    q   = s >> sh;
    rem = s - (q << sh);
    e   = p - 6;
    if (sh > 0) begin
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end
    if (q == 300'd256) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b011, neg, 8'hFF, 7'd0};
    return {2'b00, rem != 0, neg, 8'(e), q[6:0]};
  endfunction

  function automatic logic [15:0] rand_op(input logic [15:0] other);
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v[14:7] = 8'h00;
      1: v[14:7] = 8'hFF;
      2: v[14:7] = 8'hFE;
      3, 4: v[14:7] = other[14:7] ^ 8'($urandom_range(0, 3));
      default: ;
    endcase
    return v;
  endfunction

  task automatic drive(input logic v, input logic op, input logic [15:0] x,
                       input logic [15:0] y);
    in_valid = v;
    inst     = op;
    a        = x;
    b        = y;
  endtask

  task automatic init_vectors();
    dir.push_back(vec_t'{16'h3F80, 16'h4000, 1'b1, 16'h4040, 3'b000});
    dir.push_back(vec_t'{16'h3F80, 16'h3F80, 1'b0, 16'h0000, 3'b000});
    dir.push_back(vec_t'{16'h8000, 16'h8000, 1'b1, 16'h8000, 3'b000});
    dir.push_back(vec_t'{16'h8000, 16'h0000, 1'b0, 16'h8000, 3'b000});
    dir.push_back(vec_t'{16'h4040, 16'h3F80, 1'b0, 16'h4000, 3'b000});
    dir.push_back(vec_t'{16'h3F80, 16'hBF80, 1'b1, 16'h0000, 3'b000});
    dir.push_back(vec_t'{16'h3F80, 16'h3B80, 1'b1, 16'h3F80, 3'b001});
    dir.push_back(vec_t'{16'h3F81, 16'h3B80, 1'b1, 16'h3F82, 3'b001});
    dir.push_back(vec_t'{16'h3F80, 16'h3B81, 1'b1, 16'h3F81, 3'b001});
    dir.push_back(vec_t'{16'h7F7F, 16'h7F7F, 1'b1, 16'h7F80, 3'b011});
    dir.push_back(vec_t'{16'h7F80, 16'hFF80, 1'b1, 16'h7FC0, 3'b100});
    dir.push_back(vec_t'{16'h7F80, 16'h7F80, 1'b0, 16'h7FC0, 3'b100});
    dir.push_back(vec_t'{16'h7FC1, 16'h3F80, 1'b1, 16'h7FC0, 3'b000});
    dir.push_back(vec_t'{16'h7F80, 16'h3F80, 1'b0, 16'h7F80, 3'b000});
    dir.push_back(vec_t'{16'h3FC0, 16'h3FC0, 1'b1, 16'h4040, 3'b000});
    dir.push_back(vec_t'{16'h4000, 16'h4040, 1'b0, 16'hBF80, 3'b000});
`ifdef BF16_SUBNORMAL_EN
    dir.push_back(vec_t'{16'h0001, 16'h0001, 1'b1, 16'h0002, 3'b000});
    dir.push_back(vec_t'{16'h0040, 16'h0040, 1'b1, 16'h0080, 3'b000});
    dir.push_back(vec_t'{16'h0081, 16'h0080, 1'b0, 16'h0001, 3'b000});
`else
    dir.push_back(vec_t'{16'h0001, 16'h0001, 1'b1, 16'h0000, 3'b000});
    dir.push_back(vec_t'{16'h0040, 16'h0040, 1'b1, 16'h0000, 3'b000});
    dir.push_back(vec_t'{16'h0081, 16'h0080, 1'b0, 16'h0000, 3'b001});
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 16'h3F80, 16'h4000);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({c, out_valid, invalid, overflow, inexact} !== 20'h0) begin
      failures++;
      $display("FAIL reset: got c=%h v=%b flags=%b%b%b, expected all zero",
               c, out_valid, invalid, overflow, inexact);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 16'h0000, 16'h0000);
    checks++;
    if ({c, out_valid, invalid, overflow, inexact} !== {16'h4040, 4'b1000}) begin
      failures++;
      $display("FAIL first_add: got c=%h v=%b flags=%b%b%b, expected c=4040 v=1 flags=000",
               c, out_valid, invalid, overflow, inexact);
    end
  endtask

  // Each vector followed by an idle cycle: result valid, then valid drops and output holds.
  task automatic test_directed();
    foreach (dir[i]) begin
      drive(1'b1, dir[i].op, dir[i].a, dir[i].b);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b1, 16'h1234, 16'h5678);
      checks++;
      if ({out_valid, c, invalid, overflow, inexact} !== {1'b1, dir[i].c, dir[i].f}) begin
        failures++;
        $display("FAIL directed[%0d] %h %s %h: got v=%b c=%h flags=%b%b%b, expected v=1 c=%h flags=%b",
                 i, dir[i].a, dir[i].op ? "+" : "-", dir[i].b, out_valid, c,
                 invalid, overflow, inexact, dir[i].c, dir[i].f);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, c, invalid, overflow, inexact} !== {1'b0, dir[i].c, dir[i].f}) begin
        failures++;
        $display("FAIL idle_hold[%0d]: got v=%b c=%h flags=%b%b%b, expected v=0 c=%h flags=%b",
                 i, out_valid, c, invalid, overflow, inexact, dir[i].c, dir[i].f);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t        s[$];
    logic [18:0] m;
    vec_t        v;
    foreach (dir[i]) s.push_back(dir[i]);
    while (s.size() < 27) begin
      v.a  = 16'($urandom);
      v.b  = rand_op(v.a);
      v.op = 1'($urandom);
      m    = model(v.a, v.b, v.op);
      v.c  = m[15:0];
      v.f  = m[18:16];
      s.push_back(v);
    end
    drive(1'b1, s[0].op, s[0].a, s[0].b);
    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      if (i + 1 < 27) drive(1'b1, s[i+1].op, s[i+1].a, s[i+1].b);
      else drive(1'b0, 1'b1, 16'h0000, 16'h0000);
      checks++;
      if ({out_valid, c, invalid, overflow, inexact} !== {1'b1, s[i].c, s[i].f}) begin
        failures++;
        $display("FAIL stream[%0d] %h %s %h: got v=%b c=%h flags=%b%b%b, expected v=1 c=%h flags=%b",
                 i, s[i].a, s[i].op ? "+" : "-", s[i].b, out_valid, c,
                 invalid, overflow, inexact, s[i].c, s[i].f);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, c, invalid, overflow, inexact} !== {1'b0, s[26].c, s[26].f}) begin
      failures++;
      $display("FAIL stream_gap: got v=%b c=%h flags=%b%b%b, expected v=0 c=%h flags=%b",
               out_valid, c, invalid, overflow, inexact, s[26].c, s[26].f);
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic        op, v, have;
    logic [18:0] m, last;
    have = 1'b0;
    last = '0;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      x  = 16'($urandom);
      y  = rand_op(x);
      op = 1'($urandom);
      drive(v, op, x, y);
      @(posedge clk);
      #1;
      if (v) begin
        m    = model(x, y, op);
        last = m;
        have = 1'b1;
        checks++;
        if ({out_valid, c, invalid, overflow, inexact} !== {1'b1, m[15:0], m[18:16]}) begin
          failures++;
          $display("FAIL random[%0d] %h %s %h: got v=%b c=%h flags=%b%b%b, expected v=1 c=%h flags=%b",
                   i, x, op ? "+" : "-", y, out_valid, c, invalid, overflow, inexact,
                   m[15:0], m[18:16]);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0 ||
            (have && {c, invalid, overflow, inexact} !== {last[15:0], last[18:16]})) begin
          failures++;
          $display("FAIL random_idle[%0d]: got v=%b c=%h flags=%b%b%b, expected v=0 c=%h flags=%b",
                   i, out_valid, c, invalid, overflow, inexact, last[15:0], last[18:16]);
        end
      end
    end
    drive(1'b0, 1'b1, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 16'h7F7F, 16'h7F7F);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 16'h3F80, 16'h3F80);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({c, out_valid, invalid, overflow, inexact} !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid: got c=%h v=%b flags=%b%b%b, expected all zero",
               c, out_valid, invalid, overflow, inexact);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    checks++;
    if ({c, out_valid, invalid, overflow, inexact} !== 20'h0) begin
      failures++;
      $display("FAIL reset_mid_idle: got c=%h v=%b flags=%b%b%b, expected all zero",
               c, out_valid, invalid, overflow, inexact);
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
